// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port round-robin arbiter and setup/strobe/release sequencer
//            for the 4x4 SRAM macro, with one-cycle per-port responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_op,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_op,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] sram_select,
    output logic              sram_operation,
    output logic              sram_enable,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_grant;
    logic              r_id;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_sram_en;
    logic              r_sram_op;
    logic              r_rsp0;
    logic              r_rsp1;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_sram_en_nx;
    logic              w_sram_op_nx;

    assign w_grant0   = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = (r_state == S_IDLE) && w_grant0 && !rst;
    assign req1_ready = (r_state == S_IDLE) && w_grant1 && !rst;
    assign w_accept   = req0_ready || req1_ready;

    always_comb begin
        w_next       = r_state;
        w_sram_en_nx = 1'b0;
        w_sram_op_nx = 1'b1;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // Pin controls are registered from the next state so the SRAM sees
        // clean, glitch-free edges; read polarity is kept whenever disabled.
        if (w_next == S_STROBE) begin
            w_sram_en_nx = 1'b1;
            w_sram_op_nx = r_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_sram_en    <= 1'b0;
            r_sram_op    <= 1'b1;
            r_rsp0       <= 1'b0;
            r_rsp1       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sram_en <= w_sram_en_nx;
            r_sram_op <= w_sram_op_nx;
            r_rsp0    <= (w_next == S_RESP) && !r_id;
            r_rsp1    <= (w_next == S_RESP) && r_id;
            if (w_accept) begin
                r_id         <= req1_ready;
                r_last_grant <= req1_ready;
                r_op         <= req1_ready ? req1_op    : req0_op;
                r_addr       <= req1_ready ? req1_addr  : req0_addr;
                r_wdata      <= req1_ready ? req1_wdata : req0_wdata;
            end
            if (r_state == S_STROBE) begin
                if (r_id) r_rdata1 <= r_op ? sram_data_out : '0;
                else      r_rdata0 <= r_op ? sram_data_out : '0;
            end
        end
    end

    assign sram_select    = r_addr;
    assign sram_data_in   = r_wdata;
    assign sram_enable    = r_sram_en;
    assign sram_operation = r_sram_op;
    assign rsp0_valid     = r_rsp0;
    assign rsp1_valid     = r_rsp1;
    assign rsp0_rdata     = r_rdata0;
    assign rsp1_rdata     = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Scoreboard bench for sram_arbiter with a behavioural 4x4 SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_op, rsp0_valid;
    logic [1:0] req0_addr;
    logic [3:0] req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_ready, req1_op, rsp1_valid;
    logic [1:0] req1_addr;
    logic [3:0] req1_wdata, rsp1_rdata;
    logic [1:0] sram_select;
    logic       sram_operation, sram_enable;
    logic [3:0] sram_data_in, sram_data_out;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(2), .DATA_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_select(sram_select), .sram_operation(sram_operation),
        .sram_enable(sram_enable), .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out)
    );

    // Behavioural SRAM macro: combinational read, write on enable with op=0.
    logic [3:0] mem [4];
    assign sram_data_out = mem[sram_select];
    always @(posedge clk) if (sram_enable && !sram_operation) mem[sram_select] <= sram_data_in;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit       port;
        bit       op;
        bit [1:0] addr;
        bit [3:0] wdata;
        bit [3:0] exp;
        int       stage;
        int       acc_cyc;
    } txn_t;

    typedef struct {
        bit port;
        int acc_cyc;
    } grant_t;

    txn_t     sb[$];
    grant_t   glog[$];
    bit [3:0] ref_mem [4];
    bit [3:0] last0 = '0;
    bit [3:0] last1 = '0;

    // Monitor: advances the in-flight access one stage per cycle and checks
    // every SRAM pin and response against the latched request.
    always @(negedge clk) begin
        txn_t t;
        bit   rv0, rv1;
        cyc++;
        rv0 = 1'b0;
        rv1 = 1'b0;
        check("rdy_excl", 32'(req0_ready & req1_ready), 0);
        if (rst) check("rdy_in_rst", 32'(req0_ready | req1_ready), 0);
        if (sb.size() > 0) begin
            t = sb[0];
            t.stage++;
            sb[0] = t;
            check("sel_stable", 32'(sram_select), 32'(t.addr));
            check("din_stable", 32'(sram_data_in), 32'(t.wdata));
            check("en", 32'(sram_enable), (t.stage == 2) ? 1 : 0);
            check("op", 32'(sram_operation), (t.stage == 2) ? 32'(t.op) : 1);
            if (t.stage == 3) begin
                rv0 = (t.port == 1'b0);
                rv1 = (t.port == 1'b1);
                check("lat", 32'(cyc - t.acc_cyc), 3);
                if (rv0) begin
                    check("rsp0_rdata", 32'(rsp0_rdata), 32'(t.exp));
                    last0 = t.exp;
                end else begin
                    check("rsp1_rdata", 32'(rsp1_rdata), 32'(t.exp));
                    last1 = t.exp;
                end
                void'(sb.pop_front());
            end
        end else begin
            check("en_idle", 32'(sram_enable), 0);
        end
        check("rsp0_valid", 32'(rsp0_valid), 32'(rv0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(rv1));
        if (!rv0) check("rsp0_hold", 32'(rsp0_rdata), 32'(last0));
        if (!rv1) check("rsp1_hold", 32'(rsp1_rdata), 32'(last1));
        if (!rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
            t.port    = req1_valid && req1_ready;
            t.op      = t.port ? req1_op    : req0_op;
            t.addr    = t.port ? req1_addr  : req0_addr;
            t.wdata   = t.port ? req1_wdata : req0_wdata;
            t.stage   = 0;
            t.acc_cyc = cyc;
            if (t.op) begin
                t.exp = ref_mem[t.addr];
            end else begin
                t.exp = '0;
                ref_mem[t.addr] = t.wdata;
            end
            sb.push_back(t);
            glog.push_back('{port: t.port, acc_cyc: cyc});
        end
        if (rst) begin
            sb.delete();
            last0 = '0;
            last1 = '0;
        end
    end

    task automatic do_req(input bit p, input bit op, input bit [1:0] a, input bit [3:0] d);
        bit ok = 1'b0;
        if (p) begin
            req1_op = op; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) ok = 1'b1;
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    initial begin
        int base;
        bit got4;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b1; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b1; req1_op = 1'b1; req1_addr = '0; req1_wdata = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_rdy0", 32'(req0_ready), 0);
            check("rst_rdy1", 32'(req1_ready), 0);
            check("rst_en", 32'(sram_enable), 0);
            check("rst_op", 32'(sram_operation), 1);
            check("rst_sel", 32'(sram_select), 0);
            check("rst_din", 32'(sram_data_in), 0);
            check("rst_rd0", 32'(rsp0_rdata), 0);
            check("rst_rd1", 32'(rsp1_rdata), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        do_req(0, 0, 2'b00, 4'b1010);
        do_req(1, 1, 2'b00, 4'b0000);
        wait_idle();

        do_req(0, 0, 2'b00, 4'b1010);
        do_req(1, 0, 2'b01, 4'b1100);
        do_req(0, 0, 2'b10, 4'b0110);
        do_req(1, 0, 2'b11, 4'b0011);
        for (int i = 0; i < 4; i++) do_req(i[0], 1, 2'(i), 4'b0000);
        wait_idle();

        // Contention right after a reset: requester 0 must win first.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_op = 1'b1; req0_addr = 2'b00; req0_valid = 1'b1;
        req1_op = 1'b1; req1_addr = 2'b01; req1_valid = 1'b1;
        base = glog.size();
        got4 = 1'b0;
        for (int i = 0; i < 40 && !got4; i++) begin
            @(posedge clk); #1;
            if (glog.size() >= base + 4) got4 = 1'b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!got4) begin
            check("contention_timeout", 0, 1);
        end else begin
            for (int i = 0; i < 4; i++) check("grant_order", 32'(glog[base+i].port), 32'(i % 2));
            for (int i = 0; i < 3; i++)
                check("grant_gap", 32'(glog[base+i+1].acc_cyc - glog[base+i].acc_cyc), 4);
        end
        wait_idle();

        // Requester changes its fields right after acceptance.
        do_req(0, 0, 2'b01, 4'b1001);
        req0_addr = 2'b11; req0_wdata = 4'b1111;
        wait_idle();
        do_req(1, 1, 2'b01, 4'b0000);
        wait_idle();

        // Reset during the STROBE cycle of a write.
        do_req(0, 0, 2'b10, 4'b0110);
        @(posedge clk); #1;
        rst = 1'b1;
        req1_op = 1'b1; req1_addr = 2'b11; req1_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
